vga_fetch_sched: RTL and testbench
==================================

// Module: vga_fetch_sched
// PURPOSE
//  Pixel-domain framebuffer fetch scheduler feeding the VGA display path.
//  - Issues word-by-word burst reads to the framebuffer master port.
//  - Buffers fetched pixels in a local FIFO.
//  - Hands pixels to the display timing generator on demand while BLANK=1.
//  - Replaces the fixed test-pattern source; keeps the FIFO ahead of scan-out.
// PARAMETERS
//  HDISP       800    active pixels per line
//  VDISP       480    active lines per frame
//  BASE_ADR    32'h0  byte address of pixel (0,0); one 32-bit word per pixel
//  FIFO_DEPTH  64     pixel FIFO entries; power of 2; must be >= BURST
//  BURST       16     words per read burst; power of 2
// PORTS
//  pixel_clk      in   1   clock
//  pixel_rst      in   1   reset, asynchronous, active-high
//  enable         in   1   1: bursts may start; 0: no new burst (current one completes)
//  frame_sync     in   1   1-cycle pulse at start of vertical blanking
//  pix_rd         in   1   pop one pixel (display in active region)
//  pix_data       out  24  FIFO head pixel, show-ahead; 24'h000000 when empty
//  pix_valid      out  1   FIFO not empty
//  underflow      out  1   sticky: pix_rd seen while FIFO empty; cleared by frame_sync
//  mem_req        out  1   read request, held high for a whole burst
//  mem_adr        out  32  byte address of the current word
//  mem_ack        in   1   1 = mem_dat valid this cycle; word consumed, address advances
//  mem_dat        in   32  read data; bits [23:0] = RGB
// BEHAVIOUR
//  - Reset values: mem_req=0, mem_adr=BASE_ADR, pix_valid=0, pix_data=0,
//    underflow=0, FIFO empty, word index=0, state=SYNC_WAIT.
//  - SYNC_WAIT: no requests. First frame_sync -> IDLE, so fetch is frame-aligned.
//  - IDLE -> BURST when: enable=1, no frame_sync this cycle, and
//    (FIFO_DEPTH - count) >= BURST.
//    mem_req rises the cycle after the condition is sampled.
//  - BURST:
//    - mem_req=1; each mem_ack pushes mem_dat[23:0] and increments the word index.
//    - After the BURST-th ack, mem_req drops next cycle -> IDLE.
//    - The free-space check guarantees no FIFO overflow; push when full never occurs.
//  - Address: mem_adr = BASE_ADR + 4*idx.
//    idx wraps HDISP*VDISP-1 -> 0, including mid-burst, and continues at BASE_ADR.
//  - FIFO:
//    - Pushed word is visible on pix_data/pix_valid 1 cycle after its mem_ack.
//    - Simultaneous push+pop: count unchanged.
//    - Pop when empty: no change, underflow<=1.
//  - frame_sync, any state except SYNC_WAIT:
//    - FIFO flushed; idx<=0; underflow<=0; state->IDLE; mem_req=0 next cycle.
//    - An ack in the frame_sync cycle is discarded.
//    - An aborted burst is not resumed.
//  - frame_sync and pix_rd in the same cycle: flush wins; no underflow set.
//  - Reset mid-burst: immediate return to reset values; mem_req drops asynchronously.
// CONFIGURATION
//  VGA_FETCH_STATS_EN defined:
//    - Adds output underflow_cnt [15:0]: counts empty-FIFO pops.
//    - Saturates at 16'hFFFF; cleared on reset and frame_sync.
//  VGA_FETCH_STATS_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. Reset, enable=1, no frame_sync for 1000 cycles -> mem_req stays 0.
//  2. frame_sync, mem_ack always 1, no pops:
//     - bursts of 16 at adr 0x0, 0x40, 0x80, 0xC0;
//     - FIFO full at 64 entries (pix_valid=1); no 5th burst.
//  3. FIFO full, pop 16 pixels -> next burst at adr 0x100.
//     Popped data equals mem_dat[23:0] in order.
//  4. frame_sync after 8 acks of a burst:
//     - mem_req=0 next cycle; pix_valid=0;
//     - next burst restarts at adr 0x0; underflow=0.
//  5. Pop with FIFO empty -> underflow=1, pix_data=0.
//     With VGA_FETCH_STATS_EN: 3 such pops -> underflow_cnt=3.
//  6. HDISP=4, VDISP=2, BURST=4, 8 pops per frame:
//     - words at 0x00..0x1C, then wrap to 0x00 without frame_sync;
//     - enable=0 mid-burst: current burst completes, no further mem_req.

Source files
------------

// File: rtl/vga_fetch_sched.sv
// Pixel-domain framebuffer fetch scheduler: bursts framebuffer words into a
// show-ahead pixel FIFO that the display timing generator drains on demand.
// Optional build macro VGA_FETCH_STATS_EN adds a saturating underflow counter.
module vga_fetch_sched #(
    parameter int unsigned HDISP      = 800,
    parameter int unsigned VDISP      = 480,
    parameter logic [31:0] BASE_ADR   = 32'h0,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter int unsigned BURST      = 16
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        enable,
    input  logic        frame_sync,
    input  logic        pix_rd,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        underflow,
    output logic        mem_req,
    output logic [31:0] mem_adr,
    input  logic        mem_ack,
    input  logic [31:0] mem_dat
`ifdef VGA_FETCH_STATS_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam int unsigned FRAME_WORDS = HDISP * VDISP;
    localparam int unsigned IDX_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int unsigned PIX_W  = 24;

    localparam logic [1:0] ST_SYNC_WAIT = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_BURST     = 2'd2;

    logic [1:0]        state, state_nxt;
    logic              req_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic [PTR_W-1:0]  rd_ptr, rd_nxt, wr_ptr, wr_nxt;
    logic [CNT_W-1:0]  count, cnt_nxt;
    logic [PIX_W-1:0]  head_nxt;
    logic [PIX_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic              push, pop, flush, uf_set, empty, has_room;
    logic              unused_bits;

    assign empty       = (count == CNT_W'(0));
    assign has_room    = (count <= CNT_W'(FIFO_DEPTH - BURST));
    assign unused_bits = ^mem_dat[31:24];

    // State register
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) state <= ST_SYNC_WAIT;
        else           state <= state_nxt;
    end

    // Next-state, fetch sequencing and FIFO control
    always_comb begin
        state_nxt = state;
        req_nxt   = mem_req;
        idx_nxt   = idx;
        beat_nxt  = beat;
        push      = 1'b0;
        flush     = 1'b0;
        if (frame_sync) begin
            // Frame boundary aborts any burst and realigns fetch to pixel (0,0)
            flush     = 1'b1;
            idx_nxt   = '0;
            beat_nxt  = '0;
            req_nxt   = 1'b0;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_SYNC_WAIT: ;
                ST_IDLE: begin
                    if (enable && has_room) begin
                        state_nxt = ST_BURST;
                        req_nxt   = 1'b1;
                        beat_nxt  = '0;
                    end
                end
                ST_BURST: begin
                    if (mem_ack) begin
                        push     = 1'b1;
                        idx_nxt  = (idx == IDX_W'(FRAME_WORDS - 1)) ? '0 : idx + IDX_W'(1);
                        beat_nxt = beat + BEAT_W'(1);
                        if (beat == BEAT_W'(BURST - 1)) begin
                            beat_nxt  = '0;
                            req_nxt   = 1'b0;
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: state_nxt = ST_SYNC_WAIT;
            endcase
        end
        pop    = pix_rd && !empty && !frame_sync;
        uf_set = pix_rd && empty && !frame_sync;
    end

    // FIFO pointer/count update and next show-ahead head value
    always_comb begin
        rd_nxt  = rd_ptr;
        wr_nxt  = wr_ptr;
        cnt_nxt = count;
        if (flush) begin
            rd_nxt  = '0;
            wr_nxt  = '0;
            cnt_nxt = '0;
        end else begin
            if (pop)  rd_nxt = rd_ptr + PTR_W'(1);
            if (push) wr_nxt = wr_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_nxt = count + CNT_W'(1);
                2'b01:   cnt_nxt = count - CNT_W'(1);
                default: cnt_nxt = count;
            endcase
        end
        if (cnt_nxt == CNT_W'(0))           head_nxt = '0;
        else if (push && wr_ptr == rd_nxt)  head_nxt = mem_dat[PIX_W-1:0];
        else                                head_nxt = fifo_mem[rd_nxt];
    end

    // Registered outputs and datapath state
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            mem_req   <= 1'b0;
            mem_adr   <= BASE_ADR;
            idx       <= '0;
            beat      <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            underflow <= 1'b0;
        end else begin
            mem_req   <= req_nxt;
            mem_adr   <= BASE_ADR + (32'(idx_nxt) << 2);
            idx       <= idx_nxt;
            beat      <= beat_nxt;
            rd_ptr    <= rd_nxt;
            wr_ptr    <= wr_nxt;
            count     <= cnt_nxt;
            pix_data  <= head_nxt;
            pix_valid <= (cnt_nxt != CNT_W'(0));
            if (flush)       underflow <= 1'b0;
            else if (uf_set) underflow <= 1'b1;
        end
    end

    // Pixel storage; contents are qualified by count so no reset is needed
    always_ff @(posedge pixel_clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_dat[PIX_W-1:0];
    end

`ifdef VGA_FETCH_STATS_EN
    // Saturating count of pops attempted on an empty FIFO
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst)                          underflow_cnt <= 16'h0000;
        else if (frame_sync)                    underflow_cnt <= 16'h0000;
        else if (uf_set && underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed bench: default-size instance (a) and a tiny 4x2-frame instance (b).
// Honours VGA_FETCH_STATS_EN for the optional underflow counter port.
module tb_vga_fetch_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, fs_a, rd_a, valid_a, uf_a, req_a, ack_a;
    logic [23:0] data_a;
    logic [31:0] adr_a, dat_a;
    logic        rst_b, en_b, fs_b, rd_b, valid_b, uf_b, req_b, ack_b;
    logic [23:0] data_b;
    logic [31:0] adr_b, dat_b;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0] ucnt_a, ucnt_b;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Framebuffer model: pixel value is a fixed scramble of its byte address
    function automatic logic [31:0] pix(input logic [31:0] a);
        return {8'h00, a[23:0] ^ 24'h5AC396};
    endfunction

    assign ack_a = 1'b1;
    assign ack_b = 1'b1;
    assign dat_a = pix(adr_a) | 32'hEE00_0000;
    assign dat_b = pix(adr_b) | 32'hEE00_0000;

    vga_fetch_sched u_a (
        .pixel_clk(clk), .pixel_rst(rst_a), .enable(en_a), .frame_sync(fs_a),
        .pix_rd(rd_a), .pix_data(data_a), .pix_valid(valid_a), .underflow(uf_a),
        .mem_req(req_a), .mem_adr(adr_a), .mem_ack(ack_a), .mem_dat(dat_a)
`ifdef VGA_FETCH_STATS_EN
        , .underflow_cnt(ucnt_a)
`endif
    );

    vga_fetch_sched #(.HDISP(4), .VDISP(2), .FIFO_DEPTH(8), .BURST(4)) u_b (
        .pixel_clk(clk), .pixel_rst(rst_b), .enable(en_b), .frame_sync(fs_b),
        .pix_rd(rd_b), .pix_data(data_b), .pix_valid(valid_b), .underflow(uf_b),
        .mem_req(req_b), .mem_adr(adr_b), .mem_ack(ack_b), .mem_dat(dat_b)
`ifdef VGA_FETCH_STATS_EN
        , .underflow_cnt(ucnt_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Burst-start monitor for instance a
    int          rises_a = 0;
    logic [31:0] start_a [16];
    logic        prev_a = 1'b0;
    always @(negedge clk) begin
        if (req_a && !prev_a && rises_a < 16) begin
            start_a[rises_a] = adr_a;
            rises_a++;
        end
        prev_a = req_a;
    end

    // Word log for instance b: every negedge with req high precedes an accepted ack
    int          log_n = 0;
    logic [31:0] log_b [32];
    always @(negedge clk) begin
        if (req_b && log_n < 32) begin
            log_b[log_n] = adr_b;
            log_n++;
        end
    end

    task automatic wait_req_a(input string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_a) break;
        end
        chk(tag, 32'(req_a), 32'd1);
    endtask

    task automatic pulse_fs_a();
        fs_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b1; fs_a = 1'b0; rd_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b1; fs_b = 1'b0; rd_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req",   32'(req_a),   32'd0);
        chk("rst_adr",   adr_a,        32'h0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_data",  32'(data_a),  32'h0);
        chk("rst_uf",    32'(uf_a),    32'd0);
`ifdef VGA_FETCH_STATS_EN
        chk("rst_ucnt",  32'(ucnt_a),  32'd0);
`endif
        rst_a = 1'b0;
        rst_b = 1'b0;

        // No fetch before the first frame_sync
        repeat (1000) @(negedge clk);
        chk("t1_rises", 32'(rises_a), 32'd0);
        chk("t1_req",   32'(req_a),   32'd0);

        // Four bursts fill the 64-entry FIFO, then fetch stops
        pulse_fs_a();
        repeat (200) @(negedge clk);
        chk("t2_rises", 32'(rises_a), 32'd4);
        for (int i = 0; i < 4; i++) chk("t2_start", start_a[i], 32'(i * 64));
        chk("t2_valid", 32'(valid_a), 32'd1);
        chk("t2_req",   32'(req_a),   32'd0);

        // Pop 16 in order; freed space triggers a burst at 0x100
        for (int k = 0; k < 16; k++) begin
            chk("t3_pix", 32'(data_a), pix(32'(k * 4)));
            rd_a = 1'b1;
            @(negedge clk);
        end
        rd_a = 1'b0;
        chk("t3_head", 32'(data_a), pix(32'h40));
        repeat (40) @(negedge clk);
        chk("t3_rises", 32'(rises_a), 32'd5);
        chk("t3_start", start_a[4],   32'h100);

        // Abort a burst after 8 acks; fetch restarts at frame origin
        for (int k = 0; k < 16; k++) begin
            chk("t4_pix", 32'(data_a), pix(32'(32'h40 + k * 4)));
            rd_a = 1'b1;
            @(negedge clk);
        end
        rd_a = 1'b0;
        wait_req_a("t4_start");
        chk("t4_start_adr", adr_a, 32'h140);
        repeat (8) @(posedge clk);
        @(negedge clk);
        pulse_fs_a();
        chk("t4_req",   32'(req_a),   32'd0);
        chk("t4_valid", 32'(valid_a), 32'd0);
        chk("t4_uf",    32'(uf_a),    32'd0);
        wait_req_a("t4_restart");
        chk("t4_restart_adr", adr_a, 32'h0);
        @(negedge clk);
        chk("t4_valid2", 32'(valid_a), 32'd1);
        chk("t4_head",   32'(data_a),  pix(32'h0));

        // Empty-FIFO pops set sticky underflow; frame_sync with pop clears it
        en_a = 1'b0;
        repeat (40) @(negedge clk);
        pulse_fs_a();
        chk("t5_valid0", 32'(valid_a), 32'd0);
        chk("t5_data0",  32'(data_a),  32'h0);
        rd_a = 1'b1;
        repeat (3) @(negedge clk);
        rd_a = 1'b0;
        chk("t5_uf",    32'(uf_a),    32'd1);
        chk("t5_data",  32'(data_a),  32'h0);
        chk("t5_valid", 32'(valid_a), 32'd0);
`ifdef VGA_FETCH_STATS_EN
        chk("t5_ucnt",  32'(ucnt_a),  32'd3);
`endif
        fs_a = 1'b1;
        rd_a = 1'b1;
        @(negedge clk);
        fs_a = 1'b0;
        rd_a = 1'b0;
        chk("t5_uf_clr", 32'(uf_a), 32'd0);
`ifdef VGA_FETCH_STATS_EN
        chk("t5_ucnt_clr", 32'(ucnt_a), 32'd0);
`endif
        chk("t5_rises", 32'(rises_a), 32'd7);

        // Asynchronous reset in the middle of a burst
        en_a = 1'b1;
        wait_req_a("rst_mid_start");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("rst_mid_req",   32'(req_a),   32'd0);
        chk("rst_mid_adr",   adr_a,        32'h0);
        chk("rst_mid_valid", 32'(valid_a), 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        repeat (50) @(negedge clk);
        chk("rst_mid_idle",  32'(req_a),   32'd0);
        chk("rst_mid_rises", 32'(rises_a), 32'd8);

        // Tiny frame: 8 words then wrap to 0 without frame_sync
        fs_b = 1'b1;
        @(negedge clk);
        fs_b = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_log_n1", 32'(log_n), 32'd8);
        for (int i = 0; i < 8; i++) chk("t6_adr", log_b[i], 32'(i * 4));
        chk("t6_valid", 32'(valid_b), 32'd1);
        chk("t6_req",   32'(req_b),   32'd0);
        for (int k = 0; k < 8; k++) begin
            chk("t6_pix", 32'(data_b), pix(32'(k * 4)));
            rd_b = 1'b1;
            @(negedge clk);
        end
        rd_b = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_log_n2", 32'(log_n), 32'd16);
        for (int i = 8; i < 16; i++) chk("t6_wrap_adr", log_b[i], 32'((i - 8) * 4));

        // Drop enable one ack into a burst: burst completes, nothing follows
        for (int k = 0; k < 4; k++) begin
            chk("t6_pix2", 32'(data_b), pix(32'(k * 4)));
            rd_b = 1'b1;
            @(negedge clk);
        end
        rd_b = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (req_b) break;
            @(negedge clk);
        end
        chk("t6_burst_start", 32'(req_b), 32'd1);
        @(posedge clk);
        @(negedge clk);
        en_b = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_log_n3", 32'(log_n), 32'd20);
        for (int i = 16; i < 20; i++) chk("t6_tail_adr", log_b[i], 32'((i - 16) * 4));
        chk("t6_req_off", 32'(req_b), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t6_pix3", 32'(data_b), pix(32'(32'h10 + k * 4)));
            rd_b = 1'b1;
            @(negedge clk);
        end
        rd_b = 1'b0;
        repeat (30) @(negedge clk);
        chk("t6_log_n4", 32'(log_n), 32'd20);
        chk("t6_valid2", 32'(valid_b), 32'd1);
        chk("t6_head",   32'(data_b),  pix(32'h0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
